// File: rtl/subband_synthesis.sv
// Synthesis side of the 16-band filterbank: per-band gain, serial MAC over one
// captured frame, then round-half-up and saturate to sfix15_En14.
module subband_lane #(
    parameter int IN_W   = 37,
    parameter int GAIN_W = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     capture,
    input  logic                     gain_wr,
    input  logic [IN_W-1:0]          band,
    input  logic [GAIN_W-1:0]        gain_data,
    output logic signed [IN_W-1:0]   snap,
    output logic signed [GAIN_W-1:0] gain
);
    localparam logic signed [GAIN_W-1:0] GAIN_ONE = {2'b01, {(GAIN_W-2){1'b0}}};

    // Gain writes ignore clk_enable so software can retune while the datapath is frozen.
    always_ff @(posedge clock) begin
        if (!reset) begin
            snap <= '0;
            gain <= GAIN_ONE;
        end else begin
            if (capture) snap <= band;
            if (gain_wr) gain <= gain_data;
        end
    end
endmodule

module subband_synthesis #(
    parameter int NBANDS = 16,
    parameter int IN_W   = 37,
    parameter int GAIN_W = 16,
    parameter int OUT_W  = 15
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clk_enable,
    input  logic [NBANDS*IN_W-1:0] band_in,
    input  logic                   frame_strobe,
    input  logic                   gain_we,
    input  logic [3:0]             gain_addr,
    input  logic [GAIN_W-1:0]      gain_data,
    output logic [OUT_W-1:0]       filter_out,
    output logic                   out_valid,
    output logic                   busy,
    output logic                   overrun
);
    localparam int PROD_W = IN_W + GAIN_W;
    localparam int ACC_W  = PROD_W + 4;
    localparam int SH_W   = ACC_W - 32;
    localparam logic signed [ACC_W-1:0] RND  = {{(ACC_W-32){1'b0}}, 1'b1, 31'b0};
    localparam logic signed [SH_W-1:0]  OMAX = SH_W'((1 << (OUT_W-1)) - 1);
    localparam logic signed [SH_W-1:0]  OMIN = SH_W'(-(1 << (OUT_W-1)));

    typedef enum logic [1:0] {IDLE, MAC, ROUND} state_t;

    state_t                    state, state_nxt;
    logic [3:0]                idx;
    logic signed [ACC_W-1:0]   acc;
    logic signed [IN_W-1:0]    snap [NBANDS];
    logic signed [GAIN_W-1:0]  gain [NBANDS];
    logic signed [PROD_W-1:0]  prod;
    logic signed [SH_W-1:0]    rnd_q;
    logic [OUT_W-1:0]          sat_q;
    logic                      capture;

    assign capture = clk_enable && (state == IDLE) && frame_strobe;

    for (genvar k = 0; k < NBANDS; k++) begin : g_lane
        subband_lane #(.IN_W(IN_W), .GAIN_W(GAIN_W)) u_lane (
            .clock     (clock),
            .reset     (reset),
            .capture   (capture),
            .gain_wr   (gain_we && (gain_addr == 4'(k))),
            .band      (band_in[k*IN_W +: IN_W]),
            .gain_data (gain_data),
            .snap      (snap[k]),
            .gain      (gain[k])
        );
    end

    assign prod  = PROD_W'(snap[idx]) * PROD_W'(gain[idx]);
    assign rnd_q = SH_W'((acc + RND) >>> 32);

    always_comb begin
        if (rnd_q > OMAX)      sat_q = OMAX[OUT_W-1:0];
        else if (rnd_q < OMIN) sat_q = OMIN[OUT_W-1:0];
        else                   sat_q = rnd_q[OUT_W-1:0];
    end

    always_ff @(posedge clock) begin
        if (!reset)          state <= IDLE;
        else if (clk_enable) state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (frame_strobe) state_nxt = MAC;
            MAC:     if (idx == 4'(NBANDS-1)) state_nxt = ROUND;
            ROUND:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            acc        <= '0;
            idx        <= '0;
            filter_out <= '0;
            out_valid  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (clk_enable) begin
                case (state)
                    IDLE: if (frame_strobe) begin
                        acc <= '0;
                        idx <= '0;
                    end
                    MAC: begin
                        acc <= acc + ACC_W'(prod);
                        idx <= idx + 4'd1;
                    end
                    ROUND: begin
                        filter_out <= sat_q;
                        out_valid  <= 1'b1;
                    end
                    default: ;
                endcase
                // A strobe landing mid-frame is dropped but remembered until reset.
                if (busy && frame_strobe) overrun <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_subband_synthesis.sv
// Bench for subband_synthesis: directed frames plus random frames against a
// sum-of-products reference with round-half-up and saturation.
module tb_subband_synthesis;
    localparam int NB = 16;
    localparam int IW = 37;
    localparam int GW = 16;
    localparam int OW = 15;

    logic             clock = 1'b0;
    logic             reset;
    logic             clk_enable;
    logic [NB*IW-1:0] band_in;
    logic             frame_strobe;
    logic             gain_we;
    logic [3:0]       gain_addr;
    logic [GW-1:0]    gain_data;
    logic [OW-1:0]    filter_out;
    logic             out_valid;
    logic             busy;
    logic             overrun;

    int total = 0;
    int passed = 0;
    int fails = 0;
    longint band_m [NB];
    longint gain_m [NB];

    subband_synthesis dut (
        .clock        (clock),
        .reset        (reset),
        .clk_enable   (clk_enable),
        .band_in      (band_in),
        .frame_strobe (frame_strobe),
        .gain_we      (gain_we),
        .gain_addr    (gain_addr),
        .gain_data    (gain_data),
        .filter_out   (filter_out),
        .out_valid    (out_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clock = ~clock;

    function automatic longint model_out();
        longint sum = 0;
        longint r;
        for (int k = 0; k < NB; k++) sum += band_m[k] * gain_m[k];
        r = (sum + 64'sd2147483648) >>> 32;
        if (r > 16383)  r = 16383;
        if (r < -16384) r = -16384;
        return r;
    endfunction

    function automatic longint rnd_band();
        logic [IW-1:0] t;
        t = IW'({$urandom, $urandom});
        if ($urandom_range(0, 3) == 0) return longint'($signed(t));
        return longint'($urandom_range(0, 32'h1FFF_FFFF)) - 64'sd268435456;
    endfunction

    function automatic longint rnd_gain();
        return longint'($urandom_range(0, 32767)) - 64'sd16384;
    endfunction

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic load_bands();
        for (int k = 0; k < NB; k++) band_in[k*IW +: IW] = IW'(band_m[k]);
    endtask

    task automatic set_gain(input int a, input longint g);
        gain_we   = 1'b1;
        gain_addr = 4'(a);
        gain_data = GW'(g);
        @(posedge clock); #1;
        gain_we   = 1'b0;
        gain_m[a] = g;
    endtask

    task automatic run_frame(input string tag, input int stall_at, input int stall_len,
                             input int strobe2_at, input int wr_at, input int exp_lat);
        longint exp_v, wr_g;
        int lat = 0;
        int busy_cnt;
        exp_v = model_out();
        wr_g  = rnd_gain();
        load_bands();
        frame_strobe = 1'b1;
        @(posedge clock); #1;
        frame_strobe = 1'b0;
        // Scramble the inputs so only the captured snapshot can produce the result.
        for (int k = 0; k < NB; k++) band_in[k*IW +: IW] = IW'({$urandom, $urandom});
        busy_cnt = busy ? 1 : 0;
        for (int c = 1; c <= 60; c++) begin
            clk_enable   = !(stall_len > 0 && c > stall_at && c <= stall_at + stall_len);
            frame_strobe = (c == strobe2_at);
            if (c == wr_at) begin
                gain_we   = 1'b1;
                gain_addr = 4'(c - 1);
                gain_data = GW'(wr_g);
            end
            @(posedge clock); #1;
            frame_strobe = 1'b0;
            clk_enable   = 1'b1;
            gain_we      = 1'b0;
            if (c == wr_at) gain_m[c-1] = wr_g;
            if (out_valid) begin
                lat = c;
                break;
            end
            if (busy) busy_cnt++;
        end
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_value"}, longint'($signed(filter_out)), exp_v);
        chk({tag, "_busy_cycles"}, busy_cnt, exp_lat);
        chk({tag, "_busy_after"}, busy, 0);
        @(posedge clock); #1;
        chk({tag, "_valid_pulse"}, out_valid, 0);
    endtask

    initial begin
        int seen;
        reset = 1'b0; clk_enable = 1'b1; frame_strobe = 1'b0;
        gain_we = 1'b0; gain_addr = '0; gain_data = '0; band_in = '0;
        for (int k = 0; k < NB; k++) gain_m[k] = 16384;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_filter_out", filter_out, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        reset = 1'b1;
        @(posedge clock); #1;

        for (int k = 0; k < NB; k++) band_m[k] = longint'(k) <<< 22;
        run_frame("t1", 0, 0, 0, 0, 17);
        chk("t1_const", longint'($signed(filter_out)), 1920);

        for (int k = 0; k < NB; k++) band_m[k] = 64'sd2147483648;
        run_frame("t2_pos", 0, 0, 0, 0, 17);
        chk("t2_pos_const", longint'($signed(filter_out)), 16383);
        for (int k = 0; k < NB; k++) band_m[k] = -64'sd2147483648;
        run_frame("t2_neg", 0, 0, 0, 0, 17);
        chk("t2_neg_const", longint'($signed(filter_out)), -16384);

        for (int k = 0; k < NB; k++) set_gain(k, 0);
        set_gain(5, 8192);
        for (int k = 0; k < NB; k++) band_m[k] = 64'sd2147483648;
        run_frame("t3", 0, 0, 0, 0, 17);
        chk("t3_const", longint'($signed(filter_out)), 4096);

        set_gain(5, 0);
        set_gain(0, 16384);
        for (int k = 1; k < NB; k++) band_m[k] = rnd_band();
        band_m[0] = 64'sd131072;
        run_frame("t4_half", 0, 0, 0, 0, 17);
        chk("t4_half_const", longint'($signed(filter_out)), 1);
        band_m[0] = -64'sd131072;
        run_frame("t4_neghalf", 0, 0, 0, 0, 17);
        chk("t4_neghalf_const", longint'($signed(filter_out)), 0);
        band_m[0] = 64'sd393216;
        run_frame("t4_3half", 0, 0, 0, 0, 17);
        chk("t4_3half_const", longint'($signed(filter_out)), 2);

        for (int k = 0; k < NB; k++) set_gain(k, rnd_gain());
        for (int f = 0; f < 6; f++) begin
            for (int k = 0; k < NB; k++) band_m[k] = rnd_band();
            if (f == 2)      run_frame("rnd_wr_same_edge", 0, 0, 0, 6, 17);
            else if (f == 4) run_frame("rnd_stall", 9, 3, 0, 0, 20);
            else             run_frame("rnd", 0, 0, 0, 0, 17);
        end

        for (int k = 0; k < NB; k++) set_gain(k, 16384);
        for (int k = 0; k < NB; k++) band_m[k] = longint'(k) <<< 22;
        run_frame("t5_ovr", 0, 0, 8, 0, 17);
        chk("t5_overrun_set", overrun, 1);
        chk("t5_ovr_const", longint'($signed(filter_out)), 1920);
        for (int k = 0; k < NB; k++) band_m[k] = longint'(k) <<< 21;
        run_frame("t5_stall", 3, 5, 0, 0, 22);
        chk("t5_overrun_sticky", overrun, 1);

        set_gain(3, -16384);
        load_bands();
        frame_strobe = 1'b1;
        @(posedge clock); #1;
        frame_strobe = 1'b0;
        seen = 0;
        for (int c = 1; c <= 10; c++) begin
            if (c == 10) reset = 1'b0;
            @(posedge clock); #1;
            if (out_valid) seen++;
        end
        reset = 1'b1;
        chk("t6_rst_filter_out", filter_out, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_overrun", overrun, 0);
        for (int c = 0; c < 25; c++) begin
            @(posedge clock); #1;
            if (out_valid) seen++;
        end
        chk("t6_no_valid", seen, 0);
        for (int k = 0; k < NB; k++) gain_m[k] = 16384;
        for (int k = 0; k < NB; k++) band_m[k] = longint'(k) <<< 22;
        run_frame("t6_after", 0, 0, 0, 0, 17);
        chk("t6_after_const", longint'($signed(filter_out)), 1920);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
